// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: byte-stream command decoder between a UART and a register file.
// Write frames (0xAA, addr, data) produce one WrEn pulse; read frames
// (0xBB, addr) produce one RdEn pulse, wait a bounded time for RdValid and
// return the read byte on the TX side, or pulse Err on timeout.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for a command byte, other bytes dropped
// S_WR_ADDR | next byte is the write address
// S_WR_DATA | next byte is the write data
// S_RD_ADDR | next byte is the read address
// S_RD_WAIT | RdEn issued, waiting for RdValid or timeout
// S_TX_SEND | read byte held until the TX side is free
module reg_cmd_ctrl #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [WIDTH-1:0]      WrData,
  input  logic [WIDTH-1:0]      RdData,
  input  logic                  RdValid,
  output logic [WIDTH-1:0]      TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_Busy,
  output logic                  Busy,
  output logic                  Err
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [WIDTH-1:0] CMD_WR = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] CMD_RD = WIDTH'(8'hBB);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_TX_SEND
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [WIDTH-1:0]      r_wdata, w_wdata_nxt;
  logic [WIDTH-1:0]      r_tx_data, w_tx_data_nxt;
  logic [WIDTH-1:0]      r_rd_byte, w_rd_byte_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_wr_en, w_wr_en_nxt;
  logic                  r_rd_en, w_rd_en_nxt;
  logic                  r_tx_vld, w_tx_vld_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_busy;

  // state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // next-state decode; the field states never abort, any byte is taken as the field
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (RX_D_VLD && RX_P_DATA == CMD_WR)      w_state_nxt = S_WR_ADDR;
        else if (RX_D_VLD && RX_P_DATA == CMD_RD) w_state_nxt = S_RD_ADDR;
      end
      S_WR_ADDR: if (RX_D_VLD) w_state_nxt = S_WR_DATA;
      S_WR_DATA: if (RX_D_VLD) w_state_nxt = S_IDLE;
      S_RD_ADDR: if (RX_D_VLD) w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        if (RdValid)           w_state_nxt = S_TX_SEND;
        else if (r_cnt == '0)  w_state_nxt = S_IDLE;
      end
      S_TX_SEND: if (!TX_Busy) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // next values of the registered outputs and the read-wait down-counter;
  // the counter is loaded with the RdEn edge so terminal count lands RD_TIMEOUT
  // cycles after RdEn
  always_comb begin
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_tx_data_nxt = r_tx_data;
    w_rd_byte_nxt = r_rd_byte;
    w_cnt_nxt     = r_cnt;
    w_wr_en_nxt   = 1'b0;
    w_rd_en_nxt   = 1'b0;
    w_tx_vld_nxt  = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      S_WR_ADDR: if (RX_D_VLD) w_addr_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
      S_WR_DATA: begin
        if (RX_D_VLD) begin
          w_wdata_nxt = RX_P_DATA;
          w_wr_en_nxt = 1'b1;
        end
      end
      S_RD_ADDR: begin
        if (RX_D_VLD) begin
          w_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
          w_rd_en_nxt = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      S_RD_WAIT: begin
        if (RdValid)          w_rd_byte_nxt = RdData;
        else if (r_cnt == '0) w_err_nxt     = 1'b1;
        else                  w_cnt_nxt     = r_cnt - 1'b1;
      end
      S_TX_SEND: begin
        if (!TX_Busy) begin
          w_tx_data_nxt = r_rd_byte;
          w_tx_vld_nxt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // output and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tx_data <= '0;
      r_rd_byte <= '0;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_tx_vld  <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_rd_byte <= w_rd_byte_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_tx_vld  <= w_tx_vld_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign Address   = r_addr;
  assign WrData    = r_wdata;
  assign WrEn      = r_wr_en;
  assign RdEn      = r_rd_en;
  assign TX_P_DATA = r_tx_data;
  assign TX_D_VLD  = r_tx_vld;
  assign Err       = r_err;
  assign Busy      = r_busy;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Testbench for reg_cmd_ctrl: frame-level stimulus pushes expected strobes
// into a queue, a negedge monitor pops and compares whenever a strobe appears.
module tb_reg_cmd_ctrl;
  localparam int WIDTH = 8;
  localparam int AW    = 4;
  localparam int RT    = 4;

  localparam int EV_NONE = 0;
  localparam int EV_WR   = 1;
  localparam int EV_RD   = 2;
  localparam int EV_TX   = 3;
  localparam int EV_ERR  = 4;

  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [WIDTH-1:0] RX_P_DATA = '0;
  logic             RX_D_VLD = 1'b0;
  logic [AW-1:0]    Address;
  logic             WrEn, RdEn;
  logic [WIDTH-1:0] WrData;
  logic [WIDTH-1:0] RdData = '0;
  logic             RdValid = 1'b0;
  logic [WIDTH-1:0] TX_P_DATA;
  logic             TX_D_VLD;
  logic             TX_Busy = 1'b0;
  logic             Busy, Err;

  reg_cmd_ctrl #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .RD_TIMEOUT(RT)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
    .RdData(RdData), .RdValid(RdValid), .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD), .TX_Busy(TX_Busy), .Busy(Busy), .Err(Err)
  );

  always #5 CLK = ~CLK;

  int  cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t pop_exp();
    ev_t e;
    e.kind = EV_NONE; e.addr = '0; e.data = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  task automatic push_exp(int kind, logic [7:0] addr, logic [7:0] data);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  // monitor: every strobe must match the next expected event
  logic prev_tx_busy = 1'b0;
  int   rden_cyc = 0;
  always @(negedge CLK) begin
    ev_t e;
    if (RST) begin
      if (WrEn || RdEn) check("wr_rd_exclusive", 32'(WrEn & RdEn), 0);
      if (WrEn) begin
        e = pop_exp();
        check("wr_event_kind", EV_WR, e.kind);
        check("wr_address", 32'(Address), 32'(e.addr));
        check("wr_data", 32'(WrData), 32'(e.data));
      end
      if (RdEn) begin
        e = pop_exp();
        check("rd_event_kind", EV_RD, e.kind);
        check("rd_address", 32'(Address), 32'(e.addr));
        rden_cyc = cyc;
      end
      if (TX_D_VLD) begin
        e = pop_exp();
        check("tx_event_kind", EV_TX, e.kind);
        check("tx_data", 32'(TX_P_DATA), 32'(e.data));
        check("tx_after_busy_low", 32'(prev_tx_busy), 0);
      end
      if (Err) begin
        e = pop_exp();
        check("err_event_kind", EV_ERR, e.kind);
        check("err_latency", 32'(cyc - rden_cyc), RT);
      end
    end
    prev_tx_busy = TX_Busy;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(logic [7:0] b);
    RX_D_VLD  = 1'b1;
    RX_P_DATA = b;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic gap(int n);
    repeat (n) tick();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (Busy && k < 50) begin
      tick();
      k++;
    end
    check("busy_returns_idle", 32'(Busy), 0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_address"}, 32'(Address), 0);
    check({tag, "_wrdata"}, 32'(WrData), 0);
    check({tag, "_tx_data"}, 32'(TX_P_DATA), 0);
    check({tag, "_strobes"}, 32'({WrEn, RdEn, TX_D_VLD, Err}), 0);
    check({tag, "_busy"}, 32'(Busy), 0);
  endtask

  task automatic do_write(logic [7:0] a, logic [7:0] d);
    push_exp(EV_WR, a & 8'h0F, d);
    send_byte(8'hAA);
    gap($urandom_range(0, 1));
    send_byte(a);
    gap($urandom_range(0, 1));
    send_byte(d);
    wait_idle();
  endtask

  // d: cycles after RdEn at which RdValid is offered (99 = never);
  // accepted only while fewer than RT cycles have elapsed since RdEn
  task automatic do_read(logic [7:0] a, logic [7:0] x, int d, int bb, bit inject);
    int last;
    push_exp(EV_RD, a & 8'h0F, 8'h00);
    if (d < RT) push_exp(EV_TX, 8'h00, x);
    else        push_exp(EV_ERR, 8'h00, 8'h00);
    send_byte(8'hBB);
    gap($urandom_range(0, 1));
    send_byte(a);
    last = (d < RT + 2) ? d : RT + 2;
    if (bb > last) last = bb;
    for (int k = 0; k <= last; k++) begin
      RdValid = (k == d);
      RdData  = (k == d) ? x : 8'($urandom);
      TX_Busy = (k < bb);
      if (inject && k == 1) begin
        RX_D_VLD  = 1'b1;
        RX_P_DATA = 8'hAA;
      end
      tick();
      RX_D_VLD = 1'b0;
      RdValid  = 1'b0;
    end
    TX_Busy = 1'b0;
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int sel;
    gap(3);
    check_reset_outputs("reset");
    RST = 1'b1;

    // command accepted on the first cycle after reset release
    do_write(8'h05, 8'h3C);
    do_read(8'h02, 8'h81, 1, 0, 1'b0);
    do_read(8'h02, 8'h81, 1, 10, 1'b0);
    do_read(8'h01, 8'h00, 99, 0, 1'b0);
    do_read(8'h03, 8'h5A, RT - 1, 0, 1'b1);
    do_read(8'h03, 8'hA5, RT, 0, 1'b0);

    send_byte(8'h11);
    gap(2);
    check("garbage_ignored_busy", 32'(Busy), 0);
    do_write(8'hF7, 8'hBB);
    do_write(8'hBB, 8'hAA);

    // reset mid write frame: no strobe afterwards, outputs back to reset values
    send_byte(8'hAA);
    send_byte(8'h04);
    RST = 1'b0;
    gap(2);
    check_reset_outputs("midframe_reset");
    RST = 1'b1;
    send_byte(8'h55);
    gap(3);
    check("midframe_reset_idle", 32'(Busy), 0);

    // reset during the read wait: late RdValid must not produce TX
    push_exp(EV_RD, 8'h06, 8'h00);
    send_byte(8'hBB);
    send_byte(8'h06);
    tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    RdValid = 1'b1;
    RdData  = 8'h77;
    tick();
    RdValid = 1'b0;
    gap(4);
    check("midread_reset_idle", 32'(Busy), 0);

    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        do_write(8'($urandom), 8'($urandom));
      end else if (sel < 8) begin
        do_read(8'($urandom), 8'($urandom), $urandom_range(1, RT + 2),
                $urandom_range(0, 6), 1'($urandom));
      end else begin
        b = 8'($urandom);
        if (b == 8'hAA || b == 8'hBB) b = 8'h00;
        send_byte(b);
      end
      gap($urandom_range(0, 2));
    end

    gap(10);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
